// File: rtl/led16_btn_ctrl.sv
// Pushbutton front end for the 16-LED driver: synchronises and debounces the power
// and mode buttons, and produces en, mod and auto_on (manual, long-press and auto modes).
module led16_btn_ctrl #(
  parameter int DB_CNT   = 1_000_000,
  parameter int LONG_CNT = 100_000_000,
  parameter int AUTO_CNT = 200_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_pwr,
  input  logic btn_mod,
  output logic en,
  output logic mod,
  output logic auto_on
);

  localparam int DB_W   = $clog2(DB_CNT);
  localparam int LONG_W = $clog2(LONG_CNT);
  localparam int AUTO_W = $clog2(AUTO_CNT);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CNT - 1);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CNT - 1);
  localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_CNT - 1);

  typedef enum logic [1:0] {
    ST_MAN  = 2'd0,
    ST_HOLD = 2'd1,
    ST_WAIT = 2'd2,
    ST_AUTO = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Bit 0 is the power button, bit 1 is the mode button.
  logic [1:0]        raw;
  logic [1:0]        sync_p0, sync_p1;
  logic [1:0]        db, db_d;
  logic [DB_W-1:0]   db_cnt [2];
  logic [1:0]        press, release_ev;
  logic              pwr_press, mod_press, mod_rel;

  logic [LONG_W-1:0] hold_cnt, hold_cnt_nxt;
  logic [AUTO_W-1:0] auto_cnt, auto_cnt_nxt;
  logic              en_nxt, mod_nxt;

  assign raw = {btn_mod, btn_pwr};

  // Stage p0/p1: two-flop synchroniser, then per-button debounce counter
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      db      <= '0;
      db_d    <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      db_d    <= db;
      for (int i = 0; i < 2; i++) begin
        if (sync_p1[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db[i]     <= sync_p1[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign press      = db & ~db_d;
  assign release_ev = ~db & db_d;
  assign pwr_press  = press[0];
  assign mod_press  = press[1];
  assign mod_rel    = release_ev[1];

  // A power press pre-empts any mode event in the same cycle.
  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    auto_cnt_nxt = auto_cnt;
    mod_nxt      = mod;
    en_nxt       = en ^ pwr_press;
    if (en && pwr_press) begin
      state_nxt    = ST_MAN;
      hold_cnt_nxt = '0;
      auto_cnt_nxt = '0;
    end else if (en) begin
      case (state)
        ST_MAN: begin
          if (mod_press) begin
            state_nxt    = ST_HOLD;
            hold_cnt_nxt = '0;
          end
        end
        ST_HOLD: begin
          if (mod_rel) begin
            mod_nxt   = ~mod;
            state_nxt = ST_MAN;
          end else if (hold_cnt == LONG_LAST) begin
            state_nxt = ST_WAIT;
          end else begin
            hold_cnt_nxt = hold_cnt + 1'b1;
          end
        end
        ST_WAIT: begin
          if (mod_rel) begin
            state_nxt    = ST_AUTO;
            auto_cnt_nxt = '0;
          end
        end
        ST_AUTO: begin
          if (mod_press) begin
            state_nxt = ST_MAN;
          end else if (auto_cnt == AUTO_LAST) begin
            mod_nxt      = ~mod;
            auto_cnt_nxt = '0;
          end else begin
            auto_cnt_nxt = auto_cnt + 1'b1;
          end
        end
        default: state_nxt = ST_MAN;
      endcase
    end
  end

  // Stage p2: registered control state and outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_MAN;
      hold_cnt <= '0;
      auto_cnt <= '0;
      en       <= 1'b0;
      mod      <= 1'b0;
      auto_on  <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
      auto_cnt <= auto_cnt_nxt;
      en       <= en_nxt;
      mod      <= mod_nxt;
      auto_on  <= (state_nxt == ST_WAIT) || (state_nxt == ST_AUTO);
    end
  end

endmodule

// File: tb/tb_led16_btn_ctrl.sv
// Scoreboard bench for led16_btn_ctrl: directed scenarios plus random button activity,
// checked cycle by cycle against a behavioural model of the button rules.
module tb_led16_btn_ctrl;

  localparam int DB   = 4;
  localparam int LONG = 16;
  localparam int AUTO = 8;

  localparam int PH_MAN  = 0;
  localparam int PH_HOLD = 1;
  localparam int PH_WAIT = 2;
  localparam int PH_AUTO = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_pwr = 1'b0;
  logic btn_mod = 1'b0;
  logic en, mod, auto_on;

  led16_btn_ctrl #(.DB_CNT(DB), .LONG_CNT(LONG), .AUTO_CNT(AUTO)) dut (
    .clk(clk), .rst(rst), .btn_pwr(btn_pwr), .btn_mod(btn_mod),
    .en(en), .mod(mod), .auto_on(auto_on)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    bit en;
    bit mod;
    bit auto_on;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  // Model state: raw history for the synchroniser, debounced levels, run lengths,
  // and the button-mode behaviour expressed as a phase plus elapsed-cycle counters.
  int m_s1[2], m_s2[2], m_db[2], m_dbp[2], m_run[2];
  int m_en, m_mod, m_ph, m_held, m_auto;

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      m_s1[i] = 0; m_s2[i] = 0; m_db[i] = 0; m_dbp[i] = 0; m_run[i] = 0;
    end
    m_en = 0; m_mod = 0; m_ph = PH_MAN; m_held = 0; m_auto = 0;
  endtask

  task automatic model_step(input bit r, input bit p, input bit m);
    int  raw[2];
    bit  pp, mp, mr;
    exp_t e;
    raw[0] = p;
    raw[1] = m;
    if (r) begin
      model_clear();
    end else begin
      pp = (m_db[0] == 1) && (m_dbp[0] == 0);
      mp = (m_db[1] == 1) && (m_dbp[1] == 0);
      mr = (m_db[1] == 0) && (m_dbp[1] == 1);
      if (pp) begin
        if (m_en == 1) begin
          m_ph = PH_MAN; m_held = 0; m_auto = 0;
        end
        m_en = 1 - m_en;
      end else if (m_en == 1) begin
        if (m_ph == PH_MAN) begin
          if (mp) begin m_ph = PH_HOLD; m_held = 0; end
        end else if (m_ph == PH_HOLD) begin
          if (mr) begin m_mod = 1 - m_mod; m_ph = PH_MAN; end
          else if (m_held == LONG - 1) m_ph = PH_WAIT;
          else m_held++;
        end else if (m_ph == PH_WAIT) begin
          if (mr) begin m_ph = PH_AUTO; m_auto = 0; end
        end else begin
          if (mp) m_ph = PH_MAN;
          else if (m_auto == AUTO - 1) begin m_mod = 1 - m_mod; m_auto = 0; end
          else m_auto++;
        end
      end
      // A new level is accepted on the DB-th consecutive cycle of disagreement.
      for (int i = 0; i < 2; i++) begin
        m_dbp[i] = m_db[i];
        if (m_s2[i] != m_db[i]) begin
          m_run[i]++;
          if (m_run[i] == DB) begin
            m_db[i]  = m_s2[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
        m_s2[i] = m_s1[i];
        m_s1[i] = raw[i];
      end
    end
    e.en      = (m_en == 1);
    e.mod     = (m_mod == 1);
    e.auto_on = (m_ph == PH_WAIT) || (m_ph == PH_AUTO);
    exp_q.push_back(e);
  endtask

  task automatic step(input bit r, input bit p, input bit m);
    @(negedge clk);
    rst     = r;
    btn_pwr = p;
    btn_mod = m;
    @(posedge clk);
    cyc++;
    model_step(r, p, m);
  endtask

  task automatic hold(input bit p, input bit m, input int n);
    for (int i = 0; i < n; i++) step(1'b0, p, m);
  endtask

  // Monitor: every registered output update is compared at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({en, mod, auto_on} !== {e.en, e.mod, e.auto_on}) begin
          failures++;
          $display("FAIL outputs cyc=%0d en/mod/auto_on got=%b%b%b exp=%b%b%b",
                   cyc, en, mod, auto_on, e.en, e.mod, e.auto_on);
        end
      end
    end
  end

  initial begin
    int n;
    bit seen;
    int dur;
    bit rp, rm, rr;

    // Reset with both buttons held, then time the power-on from reset release
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1);
    #1;
    checks++;
    if ({en, mod, auto_on} !== 3'b000) begin
      failures++;
      $display("FAIL reset_state got=%b%b%b exp=000", en, mod, auto_on);
    end
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(1'b0, 1'b1, 1'b1);
      n++;
      #1;
      if (en === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || n != DB + 3) begin
      failures++;
      $display("FAIL pwr_on_latency got=%0d exp=%0d (seen=%0b)", n, DB + 3, seen);
    end
    hold(1'b0, 1'b0, 12);

    // Bounce on power button after a fresh reset, then a clean pulse
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0);
    hold(1'b1, 1'b0, 3);
    hold(1'b0, 1'b0, 2);
    hold(1'b1, 1'b0, 3);
    hold(1'b0, 1'b0, 8);
    hold(1'b1, 1'b0, 10);
    hold(1'b0, 1'b0, 10);

    // Short mode press
    hold(1'b0, 1'b1, DB + 2 + 8);
    hold(1'b0, 1'b0, 12);

    // Long press into auto mode, let it toggle, then leave with a press
    hold(1'b0, 1'b1, 30);
    hold(1'b0, 1'b0, 40);
    hold(1'b0, 1'b1, 10);
    hold(1'b0, 1'b0, 20);

    // Power off while in auto, mode presses while off, power back on
    hold(1'b0, 1'b1, 30);
    hold(1'b0, 1'b0, 14);
    hold(1'b1, 1'b0, 10);
    hold(1'b0, 1'b0, 10);
    hold(1'b0, 1'b1, 10);
    hold(1'b0, 1'b0, 10);
    hold(1'b1, 1'b0, 10);
    hold(1'b0, 1'b0, 30);

    // Both raw buttons rise in the same cycle while enabled
    hold(1'b1, 1'b1, 10);
    hold(1'b0, 1'b0, 12);

    // Reset in the middle of a long hold with the mode button still down
    hold(1'b1, 1'b0, 10);
    hold(1'b0, 1'b0, 10);
    hold(1'b0, 1'b1, 12);
    step(1'b1, 1'b0, 1'b1);
    hold(1'b0, 1'b1, 20);
    hold(1'b0, 1'b0, 10);

    // Random button activity, including short glitches and rare resets
    while (cyc < 4000) begin
      dur = $urandom_range(1, 40);
      rp  = ($urandom_range(0, 5) == 0);
      rm  = $urandom_range(0, 1) == 1;
      rr  = ($urandom_range(0, 149) == 0);
      if (rr) step(1'b1, rp, rm);
      else hold(rp, rm, dur);
    end
    hold(1'b0, 1'b0, 10);

    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
